// File: rtl/dot_acc_pkg.sv
// Shared widths, count sizing, saturation limits and rounding constant
// for the dot-accumulate / quantize datapath.
package dot_acc_pkg;

    localparam int DEF_SUM_WIDTH = 21;
    localparam int DEF_ACC_WIDTH = 24;
    localparam int DEF_NUM_TERMS = 3;
    localparam int DEF_SHIFT     = 8;
    localparam int DEF_OUT_WIDTH = 8;

    // Output register occupancy; the term counter carries the group state.
    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_t;

    // Width of a counter able to hold 0..num_terms.
    function automatic int cnt_width(input int num_terms);
        return $clog2(num_terms + 1);
    endfunction

    // Largest unsigned value representable in ow bits.
    function automatic longint sat_umax(input int ow);
        return (longint'(1) <<< ow) - 1;
    endfunction

    // Largest two's-complement value representable in ow bits.
    function automatic longint sat_smax(input int ow);
        return (longint'(1) <<< (ow - 1)) - 1;
    endfunction

    // Most negative two's-complement value representable in ow bits.
    function automatic longint sat_smin(input int ow);
        return -(longint'(1) <<< (ow - 1));
    endfunction

    // Half an LSB of the shifted result, added before the shift so the
    // truncation rounds half up.
    function automatic longint round_const(input int shift);
        return longint'(1) <<< (shift - 1);
    endfunction

endpackage

// File: rtl/dot_quant.sv
// Round, arithmetic right shift, optional ReLU and saturation from
// ACC_WIDTH down to OUT_WIDTH. Purely combinational.
// Macro DOT_ACCUM_RELU_EN: when defined, negatives go to 0 and the
// result is unsigned; otherwise the result is saturated two's-complement.
module dot_quant
    import dot_acc_pkg::*;
#(
    parameter int ACC_WIDTH = DEF_ACC_WIDTH,
    parameter int SHIFT     = DEF_SHIFT,
    parameter int OUT_WIDTH = DEF_OUT_WIDTH
) (
    input  logic signed [ACC_WIDTH-1:0] acc_in,
    output logic        [OUT_WIDTH-1:0] q_out
);

    // One extra bit so adding the rounding constant can never wrap.
    localparam int EW = ACC_WIDTH + 1;
    localparam logic signed [EW-1:0] RND = EW'(round_const(SHIFT));

`ifdef DOT_ACCUM_RELU_EN
    localparam logic signed [EW-1:0] HI_LIM = EW'(sat_umax(OUT_WIDTH));
    localparam logic signed [EW-1:0] LO_LIM = '0;
`else
    localparam logic signed [EW-1:0] HI_LIM = EW'(sat_smax(OUT_WIDTH));
    localparam logic signed [EW-1:0] LO_LIM = EW'(sat_smin(OUT_WIDTH));
`endif

    logic signed [EW-1:0] rounded;
    logic signed [EW-1:0] shifted;

    assign rounded = $signed({acc_in[ACC_WIDTH-1], acc_in}) + RND;
    assign shifted = rounded >>> SHIFT;

    // Clamp the shifted value into the representable output range.
    always_comb begin
        q_out = shifted[OUT_WIDTH-1:0];
        if (shifted > HI_LIM) begin
            q_out = HI_LIM[OUT_WIDTH-1:0];
        end else if (shifted < LO_LIM) begin
            q_out = LO_LIM[OUT_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/dot_accum_quant.sv
// Accumulates NUM_TERMS dot results plus bias per group, quantizes the
// group sum and hands it downstream through a valid/ready output register.
// Quantization mode is selected by macro DOT_ACCUM_RELU_EN (see dot_quant).
module dot_accum_quant
    import dot_acc_pkg::*;
#(
    parameter int SUM_WIDTH = DEF_SUM_WIDTH,
    parameter int ACC_WIDTH = DEF_ACC_WIDTH,
    parameter int NUM_TERMS = DEF_NUM_TERMS,
    parameter int SHIFT     = DEF_SHIFT,
    parameter int OUT_WIDTH = DEF_OUT_WIDTH
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 dot_vld,
    input  logic signed [SUM_WIDTH-1:0]          dot,
    input  logic signed [ACC_WIDTH-1:0]          bias,
    input  logic                                 clear,
    output logic                                 out_vld,
    output logic        [OUT_WIDTH-1:0]          out_data,
    input  logic                                 out_rdy,
    output logic                                 ovf_err,
    output logic        [cnt_width(NUM_TERMS)-1:0] term_cnt
);

    localparam int CNT_W = cnt_width(NUM_TERMS);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_TERMS - 1);

    logic signed [ACC_WIDTH-1:0] acc_reg, acc_next;
    logic        [CNT_W-1:0]     term_cnt_reg, term_cnt_next;
    out_state_t                  out_state_reg, out_state_next;
    logic        [OUT_WIDTH-1:0] out_data_reg, out_data_next;
    logic                        ovf_err_reg, ovf_err_next;

    logic signed [ACC_WIDTH-1:0] dot_ext;
    logic signed [ACC_WIDTH-1:0] acc_sum;
    logic        [CNT_W-1:0]     eff_cnt;
    logic                        is_first;
    logic                        is_last;
    logic        [OUT_WIDTH-1:0] q_val;
    logic                        pop;
    logic                        load;
    logic                        drop;

    // Sign-extend the incoming dot to the accumulator width bit by bit.
    for (genvar gi = 0; gi < ACC_WIDTH; gi++) begin : g_sext
        if (gi < SUM_WIDTH) begin : g_low
            assign dot_ext[gi] = dot[gi];
        end else begin : g_high
            assign dot_ext[gi] = dot[SUM_WIDTH-1];
        end
    end

    // Group sequencing: clear makes this cycle's dot term 0 of a new group.
    always_comb begin
        eff_cnt       = clear ? '0 : term_cnt_reg;
        is_first      = (eff_cnt == '0);
        is_last       = dot_vld && (eff_cnt == LAST_IDX);
        acc_sum       = (is_first ? bias : acc_reg) + dot_ext;
        acc_next      = acc_reg;
        term_cnt_next = term_cnt_reg;
        if (dot_vld) begin
            acc_next      = acc_sum;
            term_cnt_next = is_last ? '0 : eff_cnt + CNT_W'(1);
        end else if (clear) begin
            acc_next      = '0;
            term_cnt_next = '0;
        end
    end

    // The completing sum is quantized straight from the adder output.
    dot_quant #(
        .ACC_WIDTH (ACC_WIDTH),
        .SHIFT     (SHIFT),
        .OUT_WIDTH (OUT_WIDTH)
    ) u_quant (
        .acc_in (acc_sum),
        .q_out  (q_val)
    );

    // Output register: pop on handshake, load when empty or popping, drop when stalled.
    always_comb begin
        pop            = (out_state_reg == OUT_FULL) && out_rdy;
        load           = is_last && ((out_state_reg == OUT_EMPTY) || out_rdy);
        drop           = is_last && (out_state_reg == OUT_FULL) && !out_rdy;
        out_state_next = out_state_reg;
        out_data_next  = out_data_reg;
        ovf_err_next   = ovf_err_reg | drop;
        if (load) begin
            out_state_next = OUT_FULL;
            out_data_next  = q_val;
        end else if (pop) begin
            out_state_next = OUT_EMPTY;
        end
    end

    // Accumulator and term counter state.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_reg      <= '0;
            term_cnt_reg <= '0;
        end else begin
            acc_reg      <= acc_next;
            term_cnt_reg <= term_cnt_next;
        end
    end

    // Output register occupancy, held data and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_state_reg <= OUT_EMPTY;
            out_data_reg  <= '0;
            ovf_err_reg   <= 1'b0;
        end else begin
            out_state_reg <= out_state_next;
            out_data_reg  <= out_data_next;
            ovf_err_reg   <= ovf_err_next;
        end
    end

    assign out_vld  = (out_state_reg == OUT_FULL);
    assign out_data = out_data_reg;
    assign ovf_err  = ovf_err_reg;
    assign term_cnt = term_cnt_reg;

endmodule

// File: tb/tb_dot_accum_quant.sv
// Self-checking bench for dot_accum_quant: directed scenarios followed by
// randomized traffic, all compared against a group-level reference model.
module tb_dot_accum_quant;

    localparam int SUM_WIDTH = 21;
    localparam int ACC_WIDTH = 24;
    localparam int NUM_TERMS = 3;
    localparam int SHIFT     = 8;
    localparam int OUT_WIDTH = 8;
    localparam int CNT_W     = $clog2(NUM_TERMS + 1);

    logic                        clk = 1'b0;
    logic                        rst;
    logic                        dot_vld;
    logic signed [SUM_WIDTH-1:0] dot;
    logic signed [ACC_WIDTH-1:0] bias;
    logic                        clear;
    logic                        out_vld;
    logic        [OUT_WIDTH-1:0] out_data;
    logic                        out_rdy;
    logic                        ovf_err;
    logic        [CNT_W-1:0]     term_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: the open group and the output register.
    longint grp_sum;
    int     grp_n;
    bit     m_vld;
    longint m_data;
    bit     m_ovf;

    dot_accum_quant #(
        .SUM_WIDTH (SUM_WIDTH),
        .ACC_WIDTH (ACC_WIDTH),
        .NUM_TERMS (NUM_TERMS),
        .SHIFT     (SHIFT),
        .OUT_WIDTH (OUT_WIDTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .dot_vld  (dot_vld),
        .dot      (dot),
        .bias     (bias),
        .clear    (clear),
        .out_vld  (out_vld),
        .out_data (out_data),
        .out_rdy  (out_rdy),
        .ovf_err  (ovf_err),
        .term_cnt (term_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Wrap an exact integer sum into the signed accumulator range.
    function automatic longint wrap_acc(input longint v);
        longint m;
        m = v & ((longint'(1) <<< ACC_WIDTH) - 1);
        if (m >= (longint'(1) <<< (ACC_WIDTH - 1)))
            m = m - (longint'(1) <<< ACC_WIDTH);
        return m;
    endfunction

    // Round half up, shift, ReLU/clamp; returned as the raw output bit pattern.
    function automatic longint quant(input longint f);
        longint q;
        q = (f + (longint'(1) <<< (SHIFT - 1))) >>> SHIFT;
`ifdef DOT_ACCUM_RELU_EN
        if (q < 0) q = 0;
        if (q > (longint'(1) <<< OUT_WIDTH) - 1) q = (longint'(1) <<< OUT_WIDTH) - 1;
`else
        if (q > (longint'(1) <<< (OUT_WIDTH - 1)) - 1) q = (longint'(1) <<< (OUT_WIDTH - 1)) - 1;
        if (q < -(longint'(1) <<< (OUT_WIDTH - 1))) q = -(longint'(1) <<< (OUT_WIDTH - 1));
`endif
        return q & ((longint'(1) <<< OUT_WIDTH) - 1);
    endfunction

    // One clock: drive inputs, advance the model, then compare all outputs.
    task automatic step(input bit vld, input int d, input int b, input bit clr,
                        input bit rdy, input bit rs);
        bit     pop;
        bit     done;
        longint fin;
        dot_vld = vld;
        dot     = SUM_WIDTH'(d);
        bias    = ACC_WIDTH'(b);
        clear   = clr;
        out_rdy = rdy;
        rst     = rs;
        @(posedge clk);
        if (rs) begin
            grp_n = 0; grp_sum = 0; m_vld = 0; m_data = 0; m_ovf = 0;
        end else begin
            pop  = m_vld && rdy;
            done = 0;
            fin  = 0;
            if (clr) grp_n = 0;
            if (vld) begin
                if (grp_n == 0) grp_sum = b;
                grp_sum = grp_sum + d;
                grp_n++;
                if (grp_n == NUM_TERMS) begin
                    done  = 1;
                    fin   = wrap_acc(grp_sum);
                    grp_n = 0;
                end
            end
            if (pop) $display("[TB] pop   data=%0d", m_data);
            if (done) begin
                if (!m_vld || pop) begin
                    m_vld  = 1;
                    m_data = quant(fin);
                    $display("[TB] load  sum=%0d data=%0d", fin, m_data);
                end else begin
                    m_ovf = 1;
                    $display("[TB] drop  sum=%0d (output held)", fin);
                end
            end else if (pop) begin
                m_vld = 0;
            end
        end
        #1;
        check("out_vld", longint'(out_vld), longint'(m_vld));
        check("out_data", longint'(out_data), m_data);
        check("ovf_err", longint'(ovf_err), longint'(m_ovf));
        check("term_cnt", longint'(term_cnt), longint'(grp_n));
    endtask

    task automatic idle(input bit rdy);
        step(0, 0, 0, 0, rdy, 0);
    endtask

    task automatic group3(input int b, input int d0, input int d1, input int d2, input bit rdy);
        step(1, d0, b, 0, rdy, 0);
        step(1, d1, b, 0, rdy, 0);
        step(1, d2, b, 0, rdy, 0);
    endtask

    initial begin
        int neg_exp;
        int sat_exp;
        int d;
        int b;
`ifdef DOT_ACCUM_RELU_EN
        neg_exp = 0;
        sat_exp = 255;
`else
        neg_exp = 8'hFC;
        sat_exp = 127;
`endif
        grp_n = 0; grp_sum = 0; m_vld = 0; m_data = 0; m_ovf = 0;
        rst = 1; dot_vld = 0; dot = '0; bias = '0; clear = 0; out_rdy = 0;

        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        check("reset_vld", longint'(out_vld), 0);
        check("reset_data", longint'(out_data), 0);
        check("reset_cnt", longint'(term_cnt), 0);

        // Basic group: 600 -> 2, visible one cycle after the third dot.
        step(1, 100, 0, 0, 1, 0);
        step(1, 200, 0, 0, 1, 0);
        check("basic_early", longint'(out_vld), 0);
        step(1, 300, 0, 0, 1, 0);
        check("basic_vld", longint'(out_vld), 1);
        check("basic_data", longint'(out_data), 2);
        idle(1);

        // Negative sum -980.
        group3(0, -1000, 10, 10, 1);
        check("neg_data", longint'(out_data), longint'(neg_exp));
        idle(1);

        // Saturation: q = 391.
        group3(100000, 0, 0, 0, 1);
        check("sat_data", longint'(out_data), longint'(sat_exp));
        idle(1);

        // Backpressure: second result dropped, first held.
        group3(0, 100, 200, 300, 0);
        group3(0, 1280, 0, 0, 0);
        check("bp_data", longint'(out_data), 2);
        check("bp_ovf", longint'(ovf_err), 1);
        idle(1);
        check("bp_pop", longint'(out_vld), 0);
        group3(0, 100, 200, 300, 0);
        step(1, 1280, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 1, 0);
        check("bp_popload_vld", longint'(out_vld), 1);
        check("bp_popload_data", longint'(out_data), 5);
        idle(1);

        // Clear mid-group.
        step(1, 5, 0, 0, 1, 0);
        check("clr_cnt0", longint'(term_cnt), 1);
        step(1, 6, 0, 0, 1, 0);
        check("clr_cnt1", longint'(term_cnt), 2);
        step(1, 512, 0, 1, 1, 0);
        check("clr_cnt2", longint'(term_cnt), 1);
        step(1, 0, 0, 0, 1, 0);
        check("clr_cnt3", longint'(term_cnt), 2);
        check("clr_none", longint'(out_vld), 0);
        step(1, 0, 0, 0, 0, 0);
        check("clr_cnt4", longint'(term_cnt), 0);
        check("clr_vld", longint'(out_vld), 1);
        check("clr_data", longint'(out_data), 2);
        idle(1);

        // Reset mid-group (ovf_err is still set from backpressure).
        step(1, 7000, 0, 0, 1, 0);
        step(1, 9000, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1, 1);
        check("rst_vld", longint'(out_vld), 0);
        check("rst_ovf", longint'(ovf_err), 0);
        check("rst_cnt", longint'(term_cnt), 0);
        group3(0, 100, 200, 300, 1);
        check("rst_data", longint'(out_data), 2);
        idle(1);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0)
                d = $urandom_range(0, (1 << SUM_WIDTH) - 1) - (1 << (SUM_WIDTH - 1));
            else
                d = $urandom_range(0, 8000) - 4000;
            if ($urandom_range(0, 3) == 0)
                b = $urandom_range(0, (1 << ACC_WIDTH) - 1) - (1 << (ACC_WIDTH - 1));
            else
                b = $urandom_range(0, 60000) - 30000;
            step($urandom_range(0, 9) < 7, d, b, $urandom_range(0, 19) == 0,
                 $urandom_range(0, 9) < 6, $urandom_range(0, 99) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
